qlf_k6n10f_seg_adder_pipe: RTL and testbench
============================================

Name: qlf_k6n10f_seg_adder_pipe

Overview:
Pipelined wide adder/subtractor that splits a WIDTH-bit addition into SEG_WIDTH-bit segments, each no longer than one cluster carry chain. One segment is resolved per pipeline stage, and the inter-segment carry is registered. It sits directly downstream of the $alu carry-chain techmap: each stage's segment add is plain "+" and maps onto adder_carry cells. Wide datapaths (accumulators, address generators) use it to meet timing without a full-width ripple chain.

Parameters:
WIDTH, 32, operand and result width in bits (>= 3)
SEG_WIDTH, 10, bits resolved per stage; matches the 10-BLE cluster chain (>= 3 so each segment still maps to carry logic)
NSEG, derived = ceil(WIDTH/SEG_WIDTH), pipeline depth; the last segment may be narrower

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A, unsigned bit vector
b  input  WIDTH  operand B
bi  input  1  invert B (subtract when bi=1, ci=1)
ci  input  1  carry-in to bit 0
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
y  output  WIDTH  sum = a + (bi ? ~b : b) + ci, modulo 2^WIDTH
x  output  WIDTH  a ^ (bi ? ~b : b), the propagate vector, registered alongside y
co  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- The clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Stage k (k=0..NSEG-1) holds the following:
  - a valid bit;
  - the not-yet-summed upper operand bits (B already conditionally inverted at entry);
  - completed sum and propagate bits for segments 0..k;
  - the registered carry out of segment k.
- Stage 0 adds a[SEG-1:0] + bb[SEG-1:0] + ci at acceptance.
- Stage k adds its segment plus the registered carry from stage k-1.
- The last stage also captures the carry into its MSB to compute ovf.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, a combinational function of out_valid and out_ready only.
  - A beat is accepted when in_valid && in_ready.
  - When adv=0 every stage holds, including all data and valid bits.
  - When adv=1 each stage loads from its predecessor, and stage 0 loads the new beat or a bubble (valid=0).
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+NSEG-1. With NSEG=1 the output is valid after the accept edge itself.
- Throughput: one beat per cycle while out_ready=1. Bubbles propagate; beats are never reordered, dropped or duplicated.
- Output stability: y, x, co and ovf stay stable while out_valid=1 && out_ready=0.
- Reset: all stage valid bits clear, and out_valid, y, x, co and ovf are 0 on the cycle after reset is sampled high. in_ready=1 while out_valid=0.
  - Reset mid-operation discards every in-flight beat.
  - A beat offered during the reset cycle is not accepted.
- Arithmetic: result is modulo 2^WIDTH.
  - co and ovf are computed as for a full-width ripple add.
  - Bit-exact with the unpipelined expression {co,y} = a + bb + ci.
- Partial last segment: the last segment has width WIDTH-(NSEG-1)*SEG_WIDTH. Its carry-out is co.
- Simultaneous accept and output: on the same edge a beat enters stage 0 while the final beat is consumed.
- Out-of-range parameters: WIDTH < 3 or SEG_WIDTH < 3 is a parameter error, flagged by an elaboration-time check.

Test Plan:
1. Reset then single beat, a=0xFFFF_FFFF, b=1, bi=0, ci=0 -> after 4 cycles: y=0, co=1, ovf=0; the carry crosses all three segment boundaries.
2. Subtract, a=5, b=7, bi=1, ci=1 -> y=0xFFFF_FFFE, co=0, ovf=0. Then a=0x8000_0000, b=1, bi=1, ci=1 -> y=0x7FFF_FFFF, co=1, ovf=1.
3. Streaming 64 random beats with out_ready=1 -> one result per cycle after a 4-cycle fill, in order, matching the reference model bit-for-bit including x.
4. Backpressure: drive out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs frozen, no beat lost. On release, results resume in order.
5. Reset asserted while 3 beats are in flight -> next cycle out_valid=0 and all outputs 0. No stale beat emerges in the following 4 cycles.
6. Parameter sweep: WIDTH=3/SEG_WIDTH=3 (NSEG=1) and WIDTH=21/SEG_WIDTH=10 (partial 1-bit last segment) with random beats -> bit-exact co, ovf and y.

Source files
------------

// File: rtl/qlf_k6n10f_seg_adder_pipe.sv
// Pipelined WIDTH-bit add/subtract that resolves one SEG_WIDTH-bit segment per stage,
// registering the inter-segment carry so no carry chain spans more than one cluster.
module qlf_k6n10f_seg_adder_pipe #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x,
    output logic             co,
    output logic             ovf
);

    localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

    generate
        if (WIDTH < 3 || SEG_WIDTH < 3) begin : g_param_err
            $error("qlf_k6n10f_seg_adder_pipe: WIDTH and SEG_WIDTH must both be >= 3");
        end
    endgenerate

    logic             adv;
    logic             valid_q [NSEG];
    logic             carry_q [NSEG];
    logic [WIDTH-1:0] acc_q   [NSEG];
    logic [WIDTH-1:0] prop_q  [NSEG];
    logic             ovf_reg;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // acc holds finished sum bits below the current segment and raw A bits above it.
    // The propagate vector is formed once at entry, so pending B bits are recovered
    // as A ^ propagate instead of carrying a third operand down the pipe.
    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
            localparam int LO = gi * SEG_WIDTH;
            localparam int SW = (gi == NSEG - 1) ? (WIDTH - LO) : SEG_WIDTH;

            logic             src_valid;
            logic             src_carry;
            logic [WIDTH-1:0] src_acc;
            logic [WIDTH-1:0] src_prop;
            logic [SW-1:0]    seg_a;
            logic [SW-1:0]    seg_b;
            logic [SW:0]      seg_sum;
            logic [WIDTH-1:0] acc_next;
            logic             valid_reg;
            logic             carry_reg;
            logic [WIDTH-1:0] acc_reg;
            logic [WIDTH-1:0] prop_reg;

            if (gi == 0) begin : g_entry
                assign src_valid = in_valid;
                assign src_carry = ci;
                assign src_acc   = a;
                assign src_prop  = a ^ (bi ? ~b : b);
            end else begin : g_chain
                assign src_valid = valid_q[gi-1];
                assign src_carry = carry_q[gi-1];
                assign src_acc   = acc_q[gi-1];
                assign src_prop  = prop_q[gi-1];
            end

            assign seg_a   = src_acc[LO +: SW];
            assign seg_b   = seg_a ^ src_prop[LO +: SW];
            assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SW{1'b0}}, src_carry};

            always_comb begin
                acc_next           = src_acc;
                acc_next[LO +: SW] = seg_sum[SW-1:0];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    acc_reg   <= '0;
                    prop_reg  <= '0;
                end else if (adv) begin
                    valid_reg <= src_valid;
                    carry_reg <= seg_sum[SW];
                    acc_reg   <= acc_next;
                    prop_reg  <= src_prop;
                end
            end

            assign valid_q[gi] = valid_reg;
            assign carry_q[gi] = carry_reg;
            assign acc_q[gi]   = acc_reg;
            assign prop_q[gi]  = prop_reg;

            if (gi == NSEG - 1) begin : g_last
                // Carry into the MSB is sum_msb ^ propagate_msb; ovf compares it with carry out.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        ovf_reg <= 1'b0;
                    end else if (adv) begin
                        ovf_reg <= seg_sum[SW] ^ seg_sum[SW-1] ^ src_prop[WIDTH-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = valid_q[NSEG-1];
    assign y         = acc_q[NSEG-1];
    assign x         = prop_q[NSEG-1];
    assign co        = carry_q[NSEG-1];
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_qlf_k6n10f_seg_adder_pipe.sv
// Bench for qlf_k6n10f_seg_adder_pipe: directed vector table plus random streams on three
// parameterisations, all checked against a plain-arithmetic reference with a scoreboard.
module tb_qlf_k6n10f_seg_adder_pipe;

    localparam int NDUT  = 3;
    localparam int NSEG0 = 4;

    typedef struct {
        logic [31:0] y;
        logic [31:0] x;
        logic        co;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic        ci;
        logic [31:0] y;
        logic [31:0] x;
        logic        co;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_v [NDUT];
    logic [31:0] b_v [NDUT];
    logic        bi_v [NDUT];
    logic        ci_v [NDUT];
    logic        in_valid_v [NDUT];
    logic        out_ready_v [NDUT];
    logic        in_ready_v [NDUT];
    logic        out_valid_v [NDUT];
    logic [31:0] y_v [NDUT];
    logic [31:0] x_v [NDUT];
    logic        co_v [NDUT];
    logic        ovf_v [NDUT];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pop_cnt [NDUT];
    bit   track = 0;
    int   first_pop = -1;
    int   last_pop  = -1;
    res_t exp_q [NDUT][$];
    vec_t vecs [8];

    always #5 clk = ~clk;

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : ((d == 1) ? 3 : 21);
    endfunction

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 32 : ((gi == 1) ? 3 : 21);
            localparam int S = (gi == 1) ? 3 : 10;
            logic [W-1:0] y_w;
            logic [W-1:0] x_w;
            logic         in_ready_w;
            logic         out_valid_w;
            logic         co_w;
            logic         ovf_w;

            qlf_k6n10f_seg_adder_pipe #(.WIDTH(W), .SEG_WIDTH(S)) u_dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid_v[gi]),
                .in_ready  (in_ready_w),
                .a         (a_v[gi][W-1:0]),
                .b         (b_v[gi][W-1:0]),
                .bi        (bi_v[gi]),
                .ci        (ci_v[gi]),
                .out_valid (out_valid_w),
                .out_ready (out_ready_v[gi]),
                .y         (y_w),
                .x         (x_w),
                .co        (co_w),
                .ovf       (ovf_w)
            );

            assign y_v[gi]         = 32'(y_w);
            assign x_v[gi]         = 32'(x_w);
            assign in_ready_v[gi]  = in_ready_w;
            assign out_valid_v[gi] = out_valid_w;
            assign co_v[gi]        = co_w;
            assign ovf_v[gi]       = ovf_w;
        end
    endgenerate

    // Reference: full-width integer add; overflow from operand/result sign bits.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic bi, input logic ci);
        logic [63:0] m, aa, bb, full;
        res_t r;
        m      = (64'd1 << w) - 64'd1;
        aa     = {32'd0, a} & m;
        bb     = {32'd0, (bi ? ~b : b)} & m;
        full   = aa + bb + {63'd0, ci};
        r.y    = full[31:0] & m[31:0];
        r.x    = aa[31:0] ^ bb[31:0];
        r.co   = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: head of queue must be on the outputs whenever out_valid is high.
    always @(negedge clk) begin : mon
        res_t e;
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            if (reset) begin
                exp_q[d].delete();
            end else begin
                chk($sformatf("in_ready%0d", d), 96'(in_ready_v[d]),
                    96'(!out_valid_v[d] || out_ready_v[d]));
                if (out_valid_v[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("spurious_valid%0d", d), 96'(out_valid_v[d]), 96'd0);
                    end else begin
                        e = exp_q[d][0];
                        chk($sformatf("result%0d", d),
                            {y_v[d], x_v[d], co_v[d], ovf_v[d], 30'd0},
                            {e.y, e.x, e.co, e.ovf, 30'd0});
                        if (out_ready_v[d]) begin
                            void'(exp_q[d].pop_front());
                            pop_cnt[d]++;
                            if (d == 0 && track) begin
                                if (first_pop < 0) first_pop = cyc;
                                last_pop = cyc;
                            end
                            $display("dut%0d beat y=%h x=%h co=%0d ovf=%0d", d,
                                     y_v[d], x_v[d], co_v[d], ovf_v[d]);
                        end
                    end
                end
                if (in_valid_v[d] && in_ready_v[d])
                    exp_q[d].push_back(model(width_of(d), a_v[d], b_v[d], bi_v[d], ci_v[d]));
            end
        end
    end

    task automatic drive_rand(input int d, input bit v);
        logic [31:0] pick;
        in_valid_v[d] = v;
        case ($urandom_range(0, 5))
            0:       pick = 32'h0;
            1:       pick = 32'hFFFF_FFFF;
            2:       pick = 32'h8000_0000 >> (32 - width_of(d));
            default: pick = $urandom;
        endcase
        a_v[d]  = pick;
        b_v[d]  = $urandom;
        bi_v[d] = 1'($urandom_range(0, 1));
        ci_v[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            step();
        end
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("%s_empty%0d", name, d), 96'(exp_q[d].size()), 96'd0);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        in_valid_v[0] = 1'b1;
        a_v[0] = v.a; b_v[0] = v.b; bi_v[0] = v.bi; ci_v[0] = v.ci;
        step();
        in_valid_v[0] = 1'b0;
        for (int i = 0; i < NSEG0 - 1; i++) begin
            chk($sformatf("vec%0d_early", idx), 96'(out_valid_v[0]), 96'd0);
            step();
        end
        chk($sformatf("vec%0d_valid", idx), 96'(out_valid_v[0]), 96'd1);
        chk($sformatf("vec%0d_value", idx),
            {y_v[0], x_v[0], co_v[0], ovf_v[0], 30'd0},
            {v.y, v.x, v.co, v.ovf, 30'd0});
        step();
    endtask

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[1] = '{32'h5,         32'h7,         1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h1,         1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFE, 1'b0, 1'b1};
        vecs[4] = '{32'h3FF,       32'h1,         1'b0, 1'b0, 32'h400,       32'h3FE,       1'b0, 1'b0};
        vecs[5] = '{32'h0,         32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6] = '{32'h0,         32'h0,         1'b1, 1'b1, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 32'h2222_2222, 32'h1DD9_9DD1, 1'b0, 1'b0};

        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b1;
            a_v[d] = '0; b_v[d] = '0; bi_v[d] = 1'b0; ci_v[d] = 1'b0;
            pop_cnt[d] = 0;
        end
        step();
        step();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_out_valid%0d", d), 96'(out_valid_v[d]), 96'd0);
            chk($sformatf("rst_outputs%0d", d), {y_v[d], x_v[d], co_v[d], ovf_v[d], 30'd0}, 96'd0);
            chk($sformatf("rst_in_ready%0d", d), 96'(in_ready_v[d]), 96'd1);
        end
        reset = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Full-rate stream: results must leave on 64 consecutive cycles.
        begin
            int pops0;
            pops0 = pop_cnt[0];
            track = 1;
            for (int i = 0; i < 64; i++) begin
                drive_rand(0, 1'b1);
                step();
            end
            in_valid_v[0] = 1'b0;
            drain("stream");
            track = 0;
            chk("stream_count", 96'(pop_cnt[0] - pops0), 96'd64);
            chk("stream_span", 96'(last_pop - first_pop), 96'd63);
        end

        // Backpressure with a full pipe.
        for (int i = 0; i < 6; i++) begin
            drive_rand(0, 1'b1);
            step();
        end
        out_ready_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand(0, 1'b1);
            step();
            chk("bp_in_ready", 96'(in_ready_v[0]), 96'd0);
            chk("bp_out_valid", 96'(out_valid_v[0]), 96'd1);
        end
        out_ready_v[0] = 1'b1;
        in_valid_v[0]  = 1'b0;
        drain("bp");

        // Random valid/ready on all three parameterisations.
        for (int c = 0; c < 300; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                drive_rand(d, $urandom_range(0, 3) != 0);
                out_ready_v[d] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        for (int d = 0; d < NDUT; d++) begin
            in_valid_v[d] = 1'b0;
            out_ready_v[d] = 1'b1;
        end
        drain("mix");

        // Reset with three beats in flight and a fourth offered during reset.
        for (int i = 0; i < 3; i++) begin
            drive_rand(0, 1'b1);
            step();
        end
        drive_rand(0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid_v[0] = 1'b0;
        chk("midrst_out_valid", 96'(out_valid_v[0]), 96'd0);
        chk("midrst_outputs", {y_v[0], x_v[0], co_v[0], ovf_v[0], 30'd0}, 96'd0);
        chk("midrst_in_ready", 96'(in_ready_v[0]), 96'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_stale", 96'(out_valid_v[0]), 96'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
